regfile_decoded: RTL



---
 rtl/regfile_decoded.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_decoded.sv
// Parametrised register file with one-hot write decoder and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_decoded #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [XLEN-1:0]          wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  output logic [2**ADDR_W-1:0]     wen_onehot,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [2**ADDR_W-1:0]     busy,
  output logic [NUM_RD-1:0]        ra_busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] wen;
  logic [Depth-1:0] iss;
  logic [Depth-1:0] busy_q;
  logic [Depth-1:0] busy_d;
  logic [XLEN-1:0]  regs_q [Depth];

  always_comb begin
    wen = '0;
    iss = '0;
    if (we) wen[wa] = 1'b1;
    if (issue_valid) iss[issue_addr] = 1'b1;
    if (ZERO_REG) begin
      wen[0] = 1'b0;
      iss[0] = 1'b0;
    end
  end

  assign wen_onehot = wen;

  // A new issue outranks a completing write to the same register: the latest producer owns it.
  assign busy_d = iss | (busy_q & ~wen);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < Depth; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else if (wen[i]) begin
        regs_q[i] <= wd;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   rd;
    logic              rb;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs_q[addr];
      rb = busy_q[addr];
      if (ZERO_REG && (addr == '0)) rd = '0;
`ifdef REGFILE_BYPASS_EN
      // wen already excludes register 0 when it is hardwired.
      if (wen[addr]) begin
        rd = wd;
        if (!iss[addr]) rb = 1'b0;
      end
`endif
    end

    assign rdata[k*XLEN +: XLEN] = rd;
    assign ra_busy[k]            = rb;
  end

endmodule
